vx_dvg_stack: RTL and testbench
===============================

// Module: vx_dvg_stack
// PURPOSE
//  Per-warp divergence (IPDOM) stack that consumes split/join commands from the warp-control unit and returns thread-mask/PC updates to the warp scheduler.
//  Also serves the combinational stack-pointer query that the warp-control unit writes back as the split result.
//  Sits between the warp-control unit's registered warp_ctl output and the scheduler's per-warp tmask/PC state.
// PARAMETERS
//  NUM_WARPS    4   warps per core
//  NUM_THREADS  4   threads per warp (tmask width)
//  STACK_SIZE   8   entries per warp stack
//  PC_WIDTH     32  PC width
//  SPW = $clog2(STACK_SIZE)+1 (local): pointer width, range 0..STACK_SIZE
// PORTS
//  clk           in   1            clock
//  reset         in   1            async active-high reset
//  split_valid   in   1            split command (valid-only, no backpressure)
//  split_wid     in   log2(NW)     warp id
//  split_is_dvg  in   1            both paths non-empty
//  split_then    in   NUM_THREADS  first-path mask
//  split_else    in   NUM_THREADS  second-path mask
//  split_pc      in   PC_WIDTH     PC of second path
//  join_valid    in   1            join command (never same cycle as split_valid)
//  join_wid      in   log2(NW)     warp id
//  join_tmask    in   NUM_THREADS  current active mask
//  join_ptr      in   SPW          pointer returned by the matching split
//  query_wid     in   log2(NW)     pointer query warp id
//  query_ptr     out  SPW          comb: ptr[query_wid]
//  upd_valid     out  1            registered scheduler update
//  upd_wid       out  log2(NW)     warp id of update
//  upd_tmask     out  NUM_THREADS  new active mask
//  upd_pc_en     out  1            redirect PC to upd_pc
//  upd_pc        out  PC_WIDTH     redirect target
//  overflow      out  1            sticky: push to full stack
//  underflow     out  1            sticky: pop of empty stack
// BEHAVIOUR
//  - Reset (async): all ptr=0, upd_*=0, overflow=underflow=0; entry storage not reset.
//  - Entry = {orig_tmask, else_tmask, else_pc, phase}; ptr[w] = occupancy; top = entry[ptr-1].
//  - Split, is_dvg=1, ptr<STACK_SIZE: push {then|else, else, split_pc, 0}; next cycle upd tmask=split_then, pc_en=0.
//  - Split, is_dvg=0: no push, no update (upd_valid=0).
//  - Split, is_dvg=1, ptr==STACK_SIZE: no push, overflow<=1, upd tmask=split_then.
//  - Join, join_ptr==ptr[w]: non-divergent; no state change, upd_valid=0.
//  - Join, top.phase=0: set phase=1; upd tmask=top.else_tmask, pc_en=1, pc=top.else_pc.
//  - Join, top.phase=1: pop (ptr-1); upd tmask=top.orig_tmask, pc_en=0.
//  - Join with ptr[w]==0 and join_ptr!=0: underflow<=1, no update.
//  - Latency: update registered exactly 1 cycle after command; one command/cycle.
//  - Back-to-back same warp: second command sees state written by the first (no stale read).
//  - query_ptr reflects committed state (before any same-cycle push).
//  - split_valid && join_valid together: illegal; simulation assertion, split wins.
//  - Reset mid-sequence: stacks emptied, pending update dropped.
// CONFIGURATION
//  DVG_STACK_PERF_EN defined: adds outputs perf_splits[31:0] (all splits),
//    perf_dvg[31:0] (divergent pushes), perf_max_depth[SPW-1:0] (high-water
//    mark across warps); all reset to 0, saturate at max.
//  Undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  w0 split dvg then=0011 else=1100 pc=0x100 -> query_ptr(w0) 0->1, upd tmask=0011.
//  then join ptr=0 -> upd tmask=1100 pc_en=1 pc=0x100; second join -> tmask=1111, ptr=0.
//  Split is_dvg=0 then join with returned ptr -> no upd_valid, ptr unchanged.
//  9 dvg splits on w2 (STACK_SIZE=8) -> ptr stays 8, overflow=1, w1 unaffected.
//  Split w0 cycle t, join w0 cycle t+1 -> join sees ptr=1; reset at t+2 -> all ptr=0.
//  Perf build: 3 splits (2 dvg, depth 2) -> perf_splits=3, perf_dvg=2, max_depth=2.

Source files
------------

// File: rtl/vx_dvg_stack_if.sv
// Command/update bundle between the warp-control unit, the divergence stack and the scheduler.
// master: warp-control/scheduler side; slave: the stack.
interface vx_dvg_stack_if #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned STACK_SIZE  = 8,
  parameter int unsigned PC_WIDTH    = 32
);
  localparam int unsigned WW  = $clog2(NUM_WARPS);
  localparam int unsigned SPW = $clog2(STACK_SIZE) + 1;

  logic                   split_valid;
  logic [WW-1:0]          split_wid;
  logic                   split_is_dvg;
  logic [NUM_THREADS-1:0] split_then;
  logic [NUM_THREADS-1:0] split_else;
  logic [PC_WIDTH-1:0]    split_pc;

  logic                   join_valid;
  logic [WW-1:0]          join_wid;
  logic [NUM_THREADS-1:0] join_tmask;
  logic [SPW-1:0]         join_ptr;

  logic [WW-1:0]          query_wid;
  logic [SPW-1:0]         query_ptr;

  logic                   upd_valid;
  logic [WW-1:0]          upd_wid;
  logic [NUM_THREADS-1:0] upd_tmask;
  logic                   upd_pc_en;
  logic [PC_WIDTH-1:0]    upd_pc;

  logic                   overflow;
  logic                   underflow;

  modport master (
    output split_valid, split_wid, split_is_dvg, split_then, split_else, split_pc,
    output join_valid, join_wid, join_tmask, join_ptr, query_wid,
    input  query_ptr, upd_valid, upd_wid, upd_tmask, upd_pc_en, upd_pc, overflow, underflow
  );

  modport slave (
    input  split_valid, split_wid, split_is_dvg, split_then, split_else, split_pc,
    input  join_valid, join_wid, join_tmask, join_ptr, query_wid,
    output query_ptr, upd_valid, upd_wid, upd_tmask, upd_pc_en, upd_pc, overflow, underflow
  );
endinterface

// File: rtl/vx_dvg_stack.sv
// Per-warp IPDOM divergence stack: split pushes, join flips to the else path then pops.
// Optional DVG_STACK_PERF_EN adds saturating split/push counters and a depth high-water mark.
module vx_dvg_stack #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned STACK_SIZE  = 8,
  parameter int unsigned PC_WIDTH    = 32,
  localparam int unsigned SPW        = $clog2(STACK_SIZE) + 1
) (
  input  logic            clk,
  input  logic            reset,
  vx_dvg_stack_if.slave   bus
`ifdef DVG_STACK_PERF_EN
  ,
  output logic [31:0]     perf_splits,
  output logic [31:0]     perf_dvg,
  output logic [SPW-1:0]  perf_max_depth
`endif
);
  localparam int unsigned WW  = $clog2(NUM_WARPS);
  localparam int unsigned SIW = $clog2(STACK_SIZE);

  typedef logic [SPW-1:0] ptr_t;

  ptr_t ptr_q [NUM_WARPS];
  ptr_t ptr_d [NUM_WARPS];

  // Entry storage is deliberately not reset; ptr alone defines validity.
  logic [NUM_THREADS-1:0] orig_mem  [NUM_WARPS][STACK_SIZE];
  logic [NUM_THREADS-1:0] else_mem  [NUM_WARPS][STACK_SIZE];
  logic [PC_WIDTH-1:0]    pc_mem    [NUM_WARPS][STACK_SIZE];
  logic                   phase_mem [NUM_WARPS][STACK_SIZE];

  logic                   upd_valid_q, upd_valid_d;
  logic [WW-1:0]          upd_wid_q, upd_wid_d;
  logic [NUM_THREADS-1:0] upd_tmask_q, upd_tmask_d;
  logic                   upd_pc_en_q, upd_pc_en_d;
  logic [PC_WIDTH-1:0]    upd_pc_q, upd_pc_d;
  logic                   overflow_q, underflow_q;
  logic                   ovf_set, unf_set;

  logic [WW-1:0]  cmd_wid;
  ptr_t           cur_ptr, top_ptr, push_ptr;
  logic [SIW-1:0] top_idx, push_idx;
  logic           push_en, phase_set;

  logic unused_join_tmask;
  assign unused_join_tmask = ^bus.join_tmask;

  // Split takes priority if both commands are (illegally) asserted together.
  assign cmd_wid  = bus.split_valid ? bus.split_wid : bus.join_wid;
  assign cur_ptr  = ptr_q[cmd_wid];
  assign top_ptr  = cur_ptr - SPW'(1);
  assign push_ptr = cur_ptr + SPW'(1);
  assign top_idx  = top_ptr[SIW-1:0];
  assign push_idx = cur_ptr[SIW-1:0];

  assign bus.query_ptr = ptr_q[bus.query_wid];

  always_comb begin
    ptr_d       = ptr_q;
    push_en     = 1'b0;
    phase_set   = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    upd_valid_d = 1'b0;
    upd_wid_d   = cmd_wid;
    upd_tmask_d = '0;
    upd_pc_en_d = 1'b0;
    upd_pc_d    = '0;
    if (bus.split_valid) begin
      if (bus.split_is_dvg) begin
        upd_valid_d = 1'b1;
        upd_tmask_d = bus.split_then;
        if (cur_ptr < SPW'(STACK_SIZE)) begin
          push_en        = 1'b1;
          ptr_d[cmd_wid] = push_ptr;
        end else begin
          ovf_set = 1'b1;
        end
      end
    end else if (bus.join_valid) begin
      if (bus.join_ptr == cur_ptr) begin
        // Matching split was non-divergent: nothing to unwind.
      end else if (cur_ptr == '0) begin
        unf_set = 1'b1;
      end else if (!phase_mem[cmd_wid][top_idx]) begin
        phase_set   = 1'b1;
        upd_valid_d = 1'b1;
        upd_tmask_d = else_mem[cmd_wid][top_idx];
        upd_pc_en_d = 1'b1;
        upd_pc_d    = pc_mem[cmd_wid][top_idx];
      end else begin
        ptr_d[cmd_wid] = top_ptr;
        upd_valid_d    = 1'b1;
        upd_tmask_d    = orig_mem[cmd_wid][top_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WARPS; i++) ptr_q[i] <= '0;
      upd_valid_q <= 1'b0;
      upd_wid_q   <= '0;
      upd_tmask_q <= '0;
      upd_pc_en_q <= 1'b0;
      upd_pc_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      upd_valid_q <= upd_valid_d;
      upd_wid_q   <= upd_wid_d;
      upd_tmask_q <= upd_tmask_d;
      upd_pc_en_q <= upd_pc_en_d;
      upd_pc_q    <= upd_pc_d;
      overflow_q  <= overflow_q | ovf_set;
      underflow_q <= underflow_q | unf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      orig_mem[cmd_wid][push_idx]  <= bus.split_then | bus.split_else;
      else_mem[cmd_wid][push_idx]  <= bus.split_else;
      pc_mem[cmd_wid][push_idx]    <= bus.split_pc;
      phase_mem[cmd_wid][push_idx] <= 1'b0;
    end
    if (phase_set) phase_mem[cmd_wid][top_idx] <= 1'b1;
  end

  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_wid   = upd_wid_q;
  assign bus.upd_tmask = upd_tmask_q;
  assign bus.upd_pc_en = upd_pc_en_q;
  assign bus.upd_pc    = upd_pc_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

`ifdef DVG_STACK_PERF_EN
  logic [31:0]    perf_splits_q, perf_dvg_q;
  logic [SPW-1:0] perf_max_depth_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_splits_q    <= '0;
      perf_dvg_q       <= '0;
      perf_max_depth_q <= '0;
    end else begin
      if (bus.split_valid && perf_splits_q != '1) perf_splits_q <= perf_splits_q + 32'd1;
      if (push_en && perf_dvg_q != '1) perf_dvg_q <= perf_dvg_q + 32'd1;
      if (push_en && push_ptr > perf_max_depth_q) perf_max_depth_q <= push_ptr;
    end
  end

  assign perf_splits    = perf_splits_q;
  assign perf_dvg       = perf_dvg_q;
  assign perf_max_depth = perf_max_depth_q;
`endif

  assert property (@(posedge clk) disable iff (reset) !(bus.split_valid && bus.join_valid));

endmodule

// File: tb/tb_vx_dvg_stack.sv
// Directed bench for vx_dvg_stack: reset, split/join flow, non-divergent, overflow,
// back-to-back/reset and underflow; perf counters when DVG_STACK_PERF_EN is defined.
module tb_vx_dvg_stack;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vx_dvg_stack_if #(.NUM_WARPS(4), .NUM_THREADS(4), .STACK_SIZE(8), .PC_WIDTH(32)) bus ();

`ifdef DVG_STACK_PERF_EN
  logic [31:0] perf_splits, perf_dvg;
  logic [3:0]  perf_max_depth;
`endif

  vx_dvg_stack #(
    .NUM_WARPS(4), .NUM_THREADS(4), .STACK_SIZE(8), .PC_WIDTH(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DVG_STACK_PERF_EN
    ,
    .perf_splits    (perf_splits),
    .perf_dvg       (perf_dvg),
    .perf_max_depth (perf_max_depth)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.split_valid  = 1'b0;
    bus.split_wid    = '0;
    bus.split_is_dvg = 1'b0;
    bus.split_then   = '0;
    bus.split_else   = '0;
    bus.split_pc     = '0;
    bus.join_valid   = 1'b0;
    bus.join_wid     = '0;
    bus.join_tmask   = '0;
    bus.join_ptr     = '0;
  endtask

  task automatic do_split(input logic [1:0] w, input logic dvg, input logic [3:0] t,
                          input logic [3:0] e, input logic [31:0] pc);
    idle();
    bus.split_valid = 1'b1; bus.split_wid = w; bus.split_is_dvg = dvg;
    bus.split_then = t; bus.split_else = e; bus.split_pc = pc;
  endtask

  task automatic do_join(input logic [1:0] w, input logic [3:0] tm, input logic [3:0] p);
    idle();
    bus.join_valid = 1'b1; bus.join_wid = w; bus.join_tmask = tm; bus.join_ptr = p;
  endtask

  task automatic test_reset();
    for (int w = 0; w < 4; w++) begin
      bus.query_wid = 2'(w);
      #1;
      n_vec++;
      if (bus.query_ptr !== 4'd0) begin
        n_err++; $display("FAIL reset_ptr w%0d: got %0d want 0", w, bus.query_ptr);
      end
    end
    n_vec++;
    if ({bus.upd_valid, bus.upd_tmask, bus.upd_pc_en, bus.overflow, bus.underflow} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outs: got v=%b tm=%b pe=%b ov=%b un=%b want all 0", bus.upd_valid,
               bus.upd_tmask, bus.upd_pc_en, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_split_join();
    bus.query_wid = 2'd0;
    do_split(2'd0, 1'b1, 4'b0011, 4'b1100, 32'h100);
    #1;
    n_vec++;
    if (bus.query_ptr !== 4'd0) begin
      n_err++; $display("FAIL sj_query_pre: got %0d want 0", bus.query_ptr);
    end
    step();
    do_join(2'd0, 4'b0011, 4'd0);
    n_vec++;
    if ({bus.upd_valid, bus.upd_wid, bus.upd_tmask, bus.upd_pc_en} !== {1'b1, 2'd0, 4'b0011, 1'b0}) begin
      n_err++; $display("FAIL sj_split_upd: got v=%b w=%0d tm=%b pe=%b want 1 0 0011 0",
                        bus.upd_valid, bus.upd_wid, bus.upd_tmask, bus.upd_pc_en);
    end
    n_vec++;
    if (bus.query_ptr !== 4'd1) begin
      n_err++; $display("FAIL sj_query_post: got %0d want 1", bus.query_ptr);
    end
    step();
    do_join(2'd0, 4'b1100, 4'd0);
    n_vec++;
    if ({bus.upd_valid, bus.upd_tmask, bus.upd_pc_en, bus.upd_pc} !== {1'b1, 4'b1100, 1'b1, 32'h100}) begin
      n_err++; $display("FAIL sj_join1: got v=%b tm=%b pe=%b pc=%h want 1 1100 1 00000100",
                        bus.upd_valid, bus.upd_tmask, bus.upd_pc_en, bus.upd_pc);
    end
    n_vec++;
    if (bus.query_ptr !== 4'd1) begin
      n_err++; $display("FAIL sj_ptr_after_join1: got %0d want 1", bus.query_ptr);
    end
    step();
    idle();
    n_vec++;
    if ({bus.upd_valid, bus.upd_tmask, bus.upd_pc_en} !== {1'b1, 4'b1111, 1'b0}) begin
      n_err++; $display("FAIL sj_join2: got v=%b tm=%b pe=%b want 1 1111 0",
                        bus.upd_valid, bus.upd_tmask, bus.upd_pc_en);
    end
    n_vec++;
    if (bus.query_ptr !== 4'd0) begin
      n_err++; $display("FAIL sj_ptr_after_pop: got %0d want 0", bus.query_ptr);
    end
    step();
    n_vec++;
    if (bus.upd_valid !== 1'b0) begin
      n_err++; $display("FAIL sj_idle: got upd_valid=%b want 0", bus.upd_valid);
    end
  endtask

  task automatic test_non_dvg();
    bus.query_wid = 2'd1;
    do_split(2'd1, 1'b0, 4'b1111, 4'b0000, 32'h80);
    step();
    do_join(2'd1, 4'b1111, 4'd0);
    n_vec++;
    if (bus.upd_valid !== 1'b0 || bus.query_ptr !== 4'd0) begin
      n_err++; $display("FAIL nd_split: got v=%b ptr=%0d want 0 0", bus.upd_valid, bus.query_ptr);
    end
    step();
    idle();
    n_vec++;
    if (bus.upd_valid !== 1'b0 || bus.query_ptr !== 4'd0 || bus.underflow !== 1'b0) begin
      n_err++; $display("FAIL nd_join: got v=%b ptr=%0d un=%b want 0 0 0",
                        bus.upd_valid, bus.query_ptr, bus.underflow);
    end
  endtask

  task automatic test_overflow();
    do_split(2'd1, 1'b1, 4'b1000, 4'b0100, 32'h40);
    step();
    for (int i = 0; i < 9; i++) begin
      do_split(2'd2, 1'b1, 4'b0001, 4'b0010, 32'h200 + 32'(i));
      step();
      idle();
      n_vec++;
      if (bus.upd_valid !== 1'b1 || bus.upd_wid !== 2'd2 || bus.upd_tmask !== 4'b0001) begin
        n_err++; $display("FAIL ovf_upd%0d: got v=%b w=%0d tm=%b want 1 2 0001",
                          i, bus.upd_valid, bus.upd_wid, bus.upd_tmask);
      end
      if (i == 7) begin
        n_vec++;
        if (bus.overflow !== 1'b0) begin
          n_err++; $display("FAIL ovf_early: got overflow=%b want 0 at depth 8", bus.overflow);
        end
      end
    end
    bus.query_wid = 2'd2;
    #1;
    n_vec++;
    if (bus.query_ptr !== 4'd8 || bus.overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_w2: got ptr=%0d ov=%b want 8 1", bus.query_ptr, bus.overflow);
    end
    bus.query_wid = 2'd1;
    #1;
    n_vec++;
    if (bus.query_ptr !== 4'd1) begin
      n_err++; $display("FAIL ovf_w1: got ptr=%0d want 1", bus.query_ptr);
    end
  endtask

  task automatic test_back_to_back();
    bus.query_wid = 2'd0;
    do_split(2'd0, 1'b1, 4'b0101, 4'b1010, 32'h300);
    step();
    do_join(2'd0, 4'b0101, 4'd0);
    n_vec++;
    if (bus.upd_valid !== 1'b1 || bus.upd_tmask !== 4'b0101) begin
      n_err++; $display("FAIL b2b_split: got v=%b tm=%b want 1 0101", bus.upd_valid, bus.upd_tmask);
    end
    step();
    do_join(2'd0, 4'b1010, 4'd0);
    n_vec++;
    if ({bus.upd_valid, bus.upd_tmask, bus.upd_pc_en, bus.upd_pc} !== {1'b1, 4'b1010, 1'b1, 32'h300}) begin
      n_err++; $display("FAIL b2b_join: got v=%b tm=%b pe=%b pc=%h want 1 1010 1 00000300",
                        bus.upd_valid, bus.upd_tmask, bus.upd_pc_en, bus.upd_pc);
    end
    n_vec++;
    if (bus.query_ptr !== 4'd1) begin
      n_err++; $display("FAIL b2b_ptr: got %0d want 1", bus.query_ptr);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.upd_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      n_err++; $display("FAIL b2b_reset_outs: got v=%b ov=%b want 0 0", bus.upd_valid, bus.overflow);
    end
    for (int w = 0; w < 4; w++) begin
      bus.query_wid = 2'(w);
      #1;
      n_vec++;
      if (bus.query_ptr !== 4'd0) begin
        n_err++; $display("FAIL b2b_reset_ptr w%0d: got %0d want 0", w, bus.query_ptr);
      end
    end
    step();
    idle();
    reset = 1'b0;
    step();
    n_vec++;
    if (bus.upd_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_dropped: got upd_valid=%b want 0", bus.upd_valid);
    end
  endtask

  task automatic test_underflow();
    do_join(2'd3, 4'b1111, 4'd0);
    step();
    idle();
    n_vec++;
    if (bus.upd_valid !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++; $display("FAIL unf_match: got v=%b un=%b want 0 0", bus.upd_valid, bus.underflow);
    end
    do_join(2'd3, 4'b1111, 4'd1);
    step();
    idle();
    n_vec++;
    if (bus.upd_valid !== 1'b0 || bus.underflow !== 1'b1) begin
      n_err++; $display("FAIL unf_set: got v=%b un=%b want 0 1", bus.upd_valid, bus.underflow);
    end
  endtask

`ifdef DVG_STACK_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    step();
    reset = 1'b0;
    do_split(2'd0, 1'b1, 4'b0001, 4'b1110, 32'h10);
    step();
    do_split(2'd0, 1'b1, 4'b0010, 4'b1100, 32'h20);
    step();
    do_split(2'd1, 1'b0, 4'b1111, 4'b0000, 32'h30);
    step();
    idle();
    n_vec++;
    if (perf_splits !== 32'd3 || perf_dvg !== 32'd2 || perf_max_depth !== 4'd2) begin
      n_err++; $display("FAIL perf: got splits=%0d dvg=%0d max=%0d want 3 2 2",
                        perf_splits, perf_dvg, perf_max_depth);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.query_wid = '0;
    idle();
    step();
    test_reset();
    step();
    reset = 1'b0;
    step();
    test_split_join();
    test_non_dvg();
    test_overflow();
    test_back_to_back();
    test_underflow();
`ifdef DVG_STACK_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
